// File: rtl/fetch_arbiter_pkg.sv
// Shared definitions for the fetch path: word/context types, arbiter sizing
// and the fetch arbiter state encoding.
package gDefine;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned NUM_CTX       = 32;
  localparam int unsigned FETCH_CREDITS = 4;

  typedef logic [WORD_W-1:0]           Word_t;
  typedef logic [$clog2(NUM_CTX)-1:0]  CtxID_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } fetchState_t;

endpackage

// File: rtl/fetch_arbiter_if.sv
// Bundle between the context-manager array, the fetch arbiter and the
// instruction-fetch port; master is the arbiter side.
interface fetch_arbiter_if
  import gDefine::*;
#(
  parameter int unsigned NUM_CTX       = gDefine::NUM_CTX,
  parameter int unsigned FETCH_CREDITS = gDefine::FETCH_CREDITS
);

  logic [NUM_CTX-1:0]                     reqPCValid;
  Word_t                                  PCin [NUM_CTX];
  logic [NUM_CTX-1:0]                     pcAck;
  logic                                   fetchValid;
  Word_t                                  fetchAddr;
  logic [$clog2(NUM_CTX)-1:0]             fetchTag;
  logic                                   fetchReady;
  logic                                   fetchRespValid;
  logic [$clog2(FETCH_CREDITS+1)-1:0]     creditsFree;

  modport master (
    input  reqPCValid,
    input  PCin,
    input  fetchReady,
    input  fetchRespValid,
    output pcAck,
    output fetchValid,
    output fetchAddr,
    output fetchTag,
    output creditsFree
  );

  modport slave (
    output reqPCValid,
    output PCin,
    output fetchReady,
    output fetchRespValid,
    input  pcAck,
    input  fetchValid,
    input  fetchAddr,
    input  fetchTag,
    input  creditsFree
  );

endinterface

// File: rtl/fetch_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after start,
// wrapping at N-1. Shared by the fetch, writeback and issue arbiters.
module rr_picker #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic                 found,
  output logic [$clog2(N)-1:0] winner
);

  localparam int unsigned W = $clog2(N);

  logic [W-1:0] idx;

  // Scan from the farthest slot back towards start so the last hit is the
  // nearest one; N is a power of two so the add wraps for free.
  always_comb begin
    found  = |req;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = start + W'(N - 1 - i);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/fetch_arbiter.sv
// Round-robin arbiter from per-context PC requests to the single fetch port,
// with a credit counter bounding the number of fetches in flight.
module fetch_arbiter
  import gDefine::*;
#(
  parameter int unsigned NUM_CTX       = gDefine::NUM_CTX,
  parameter int unsigned FETCH_CREDITS = gDefine::FETCH_CREDITS
) (
  input  logic            clk,
  input  logic            rst,
  fetch_arbiter_if.master bus
);

  localparam int unsigned CW = $clog2(NUM_CTX);
  localparam int unsigned KW = $clog2(FETCH_CREDITS + 1);

  fetchState_t   state;
  logic [CW-1:0] rrPtr;
  logic [CW-1:0] tagQ;
  Word_t         addrQ;
  logic          validQ;
  logic [KW-1:0] credits;

  logic          found;
  logic [CW-1:0] winner;
  logic          retOk;
  logic [KW-1:0] effCredits;
  logic          grant;

  rr_picker #(.N(NUM_CTX)) uPick (
    .req    (bus.reqPCValid),
    .start  (rrPtr),
    .found  (found),
    .winner (winner)
  );

  // A return into a full counter is dropped so the count saturates.
  always_comb begin
    retOk      = bus.fetchRespValid && (credits != KW'(FETCH_CREDITS));
    effCredits = credits + KW'(retOk);
    grant      = (state == IDLE) && found && (effCredits != '0);
  end

  always_comb begin
    bus.pcAck = '0;
    if ((state == ISSUE) && bus.fetchReady) begin
      bus.pcAck[tagQ] = 1'b1;
    end
  end

  assign bus.fetchValid  = validQ;
  assign bus.fetchAddr   = addrQ;
  assign bus.fetchTag    = tagQ;
  assign bus.creditsFree = credits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rrPtr   <= '0;
      tagQ    <= '0;
      addrQ   <= '0;
      validQ  <= 1'b0;
      credits <= KW'(FETCH_CREDITS);
    end else begin
      credits <= grant ? (effCredits - KW'(1)) : effCredits;
      unique case (state)
        IDLE: begin
          if (grant) begin
            tagQ   <= winner;
            addrQ  <= bus.PCin[winner];
            rrPtr  <= winner + CW'(1);
            validQ <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.fetchReady) begin
            validQ <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          validQ <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  creditOverflow: assert property (
    @(posedge clk) disable iff (rst)
      !(bus.fetchRespValid && (credits == KW'(FETCH_CREDITS)))
  );

endmodule

// File: doc/fetch_arbiter.md
# fetch_arbiter

Round-robin fetch arbiter between the per-context PC request ports and the single instruction-fetch port of the IO interconnect. Each cycle it selects at most one context with a pending PC request, issues that context's PC with a context tag downstream, and returns a one-cycle `pcAck` to the winner on handshake. A credit counter caps the number of fetches in flight. It sits between the context-manager array and the instruction memory path of a core.

## Interface

- `NUM_CTX`, 32: number of contexts arbitrated. Power of two, at least 2.
- `FETCH_CREDITS`, 4: maximum outstanding fetches. At least 1.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `reqPCValid` input `NUM_CTX`: per-context fetch request, level.
- `PCin` input `NUM_CTX` x `Word_t`: per-context current PC.
- `pcAck` output `NUM_CTX`: one-hot acknowledge to the granted context.
- `fetchValid` output 1: downstream request valid.
- `fetchAddr` output `Word_t`: PC being fetched.
- `fetchTag` output `CtxID_t`: context ID of the fetch.
- `fetchReady` input 1: downstream accepts the request.
- `fetchRespValid` input 1: one fetch completed; returns one credit.
- `creditsFree` output `$clog2(FETCH_CREDITS+1)`: current free credits (debug/perf).

## Operation

- State machine states:
  - `IDLE`: `fetchValid`=0. The arbiter grants when any `reqPCValid` bit is 1 and the effective credit count is greater than 0. Effective credits are `creditsFree` plus the return in the same cycle.
  - On a grant, the winner is the first set bit at or after `rrPtr`, searching upward and wrapping from `NUM_CTX`-1 to 0.
  - A grant latches `fetchTag`=winner and `fetchAddr`=`PCin[winner]`, sets `rrPtr`=(winner+1) mod `NUM_CTX`, decrements the credit count, and moves to `ISSUE`.
  - `ISSUE`: `fetchValid`=1, and `fetchAddr` and `fetchTag` stay stable until the handshake.
  - On `fetchReady`=1, `pcAck[fetchTag]`=1 combinationally in that same cycle and the state moves to `IDLE`.
- `pcAck` is 0 whenever the block is not in `ISSUE` with `fetchReady` high. It never has more than one bit set.
- The context drops `reqPCValid` on the edge at which it sees `pcAck`. The `IDLE` cycle after a handshake therefore never sees a stale request from the acked context, and no extra masking is required.
- PC is sampled at grant only. Later changes to `PCin` do not alter a request already in `ISSUE`. Core control guarantees `loadReq` is not issued to a context with a fetch in flight.
- Credit rules:
  - A credit is consumed at grant, not at handshake.
  - `fetchRespValid` adds one credit.
  - A grant and a return in the same cycle leave the count unchanged.
  - A return while the count is already `FETCH_CREDITS` is ignored, the count saturates, and a simulation assertion fires.
- With zero credits, requests wait in `IDLE`. `rrPtr` does not move and no `pcAck` is asserted.

## Timing

- Reset values: state=`IDLE`, `fetchValid`=0, `fetchAddr`=0, `fetchTag`=0, `pcAck`=0, `rrPtr`=0, `creditsFree`=`FETCH_CREDITS`.
- Reset mid-`ISSUE` drops `fetchValid` immediately, with no `pcAck`. The requesting context retries after reset.
- Grant-to-valid latency: `reqPCValid` seen in an `IDLE` cycle gives `fetchValid`=1 on the next cycle.
- Best-case throughput: one fetch per 2 cycles, with `fetchReady` held high.
- Downstream handshake is valid/ready: a transfer occurs on any edge with both high. `fetchValid` never drops without `fetchReady`.
- Fairness: every continuously requesting context is granted within `NUM_CTX` grants.

## Structure

- Shared package `gDefine` holds:
  - `Word_t`
  - `CtxID_t` = logic [$clog2(`NUM_CTX`)-1:0]
  - `NUM_CTX`
  - `FETCH_CREDITS`
- Sub-module `rr_picker`: combinational. Inputs are the request vector and the start pointer; outputs are `found` and `winner` index. It is reused by later writeback and issue arbiters.
- The top level holds the FSM, the latches, and the credit counter.

## Test plan

- Single requester: `reqPCValid[5]`=1 with `PCin[5]`=0x100 and `fetchReady`=1. Expect `fetchValid` with `fetchAddr`=0x100 and `fetchTag`=5 one cycle after the request, `pcAck[5]` in that cycle, then `fetchValid`=0.
- Round-robin: contexts 0, 3 and 31 request continuously, and ready is always high. Expect grant order 0, 3, 31, 0, 3, then a request from 31 and 0 wraps to 31 before 0.
- Backpressure: hold `fetchReady`=0 for 5 cycles while in `ISSUE`. Expect `fetchAddr`/`fetchTag` stable and `pcAck`=0 throughout, then a single ack when ready rises.
- Credit exhaustion: `FETCH_CREDITS`=4 with no responses. Expect 4 fetches, then `fetchValid` stays low. One `fetchRespValid` allows exactly one more. A simultaneous return and grant keeps `creditsFree` unchanged.
- Reset mid-`ISSUE`: assert `rst` asynchronously. Expect `fetchValid`=0 before the next edge, `creditsFree`=4, `rrPtr`=0, and no `pcAck`.
- PC change after grant: `PCin[2]` changes from 0x40 to 0x80 while in `ISSUE`. Expect `fetchAddr` to stay 0x40.
